// File: rtl/fifo_rd_master_if.sv
// Stream and FIFO read-port bundle for fifo_rd_master.
// The master modport is the controller's view; slave is the FIFO/consumer side.
interface fifo_rd_master_if #(
   parameter int FIFO_WIDTH = 16,
   parameter int LEN_W      = 8
);
   logic                  start;
   logic [LEN_W-1:0]      len;
   logic                  busy;
   logic                  done;
   logic                  fifo_empty;
   logic                  fifo_underflow;
   logic [FIFO_WIDTH-1:0] fifo_data_out;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [FIFO_WIDTH-1:0] m_data;
   logic                  err_underflow;

   modport master (
      input  start, len, fifo_empty, fifo_underflow, fifo_data_out, m_ready,
      output busy, done, fifo_rd_en, m_valid, m_data, err_underflow
   );

   modport slave (
      output start, len, fifo_empty, fifo_underflow, fifo_data_out, m_ready,
      input  busy, done, fifo_rd_en, m_valid, m_data, err_underflow
   );
endinterface

// File: rtl/fifo_rd_master.sv
// Burst read controller: pops LEN words from a registered-output FIFO and
// streams them through a 3-entry skid buffer onto a valid/ready interface.
module fifo_rd_master #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 8
) (
   input logic              clk,
   input logic              rst,
   fifo_rd_master_if.master bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Outstanding words (buffered + in flight) must fit the 3 buffer slots;
   // a shallower FIFO can never supply more than its depth anyway.
   localparam int WINDOW = (FIFO_DEPTH < 3) ? FIFO_DEPTH : 3;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [LEN_W-1:0]      issue_left;
   logic                  inflight;
   logic [1:0]            buf_count;
   logic [1:0]            buf_count_nxt;
   logic [1:0]            head;
   logic [1:0]            tail;
   logic [FIFO_WIDTH-1:0] buf_mem [3];
   logic [2:0]            occupancy;
   logic                  rd_en;
   logic                  capture;
   logic                  xfer;
   logic                  err_q;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Issue depends only on registered state, so m_ready never reaches fifo_rd_en.
   assign occupancy = {1'b0, buf_count} + {2'b00, inflight};
   assign rd_en     = !rst && (state == S_READ) && !bus.fifo_empty &&
                      (issue_left != '0) && (occupancy < 3'(WINDOW));
   assign capture   = inflight;
   assign xfer      = (buf_count != 2'd0) && bus.m_ready;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      buf_count_nxt = buf_count;
      if (capture && !xfer) begin
         buf_count_nxt = buf_count + 2'd1;
      end else if (!capture && xfer) begin
         buf_count_nxt = buf_count - 2'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nxt = (bus.len != '0) ? S_READ : S_DONE;
            end
         end
         S_READ: begin
            if (rd_en && (issue_left == LEN_W'(1))) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!inflight && (buf_count_nxt == 2'd0)) begin
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         issue_left <= '0;
         inflight   <= 1'b0;
         buf_count  <= 2'd0;
         head       <= 2'd0;
         tail       <= 2'd0;
         err_q      <= 1'b0;
      end else begin
         state     <= state_nxt;
         inflight  <= rd_en;
         buf_count <= buf_count_nxt;
         if ((state == S_IDLE) && bus.start && (bus.len != '0)) begin
            issue_left <= bus.len;
         end else if (rd_en) begin
            issue_left <= issue_left - LEN_W'(1);
         end
         if (capture) begin
            tail <= ptr_inc(tail);
         end
         if (xfer) begin
            head <= ptr_inc(head);
         end
         if (bus.fifo_underflow) begin
            err_q <= 1'b1;
         end
      end
   end

   // NOTE: buffer storage is not reset; buf_count qualifies every read of it.
   always_ff @(posedge clk) begin
      if (capture) begin
         buf_mem[tail] <= bus.fifo_data_out;
      end
   end

   assign bus.fifo_rd_en    = rd_en;
   assign bus.m_valid       = (buf_count != 2'd0);
   assign bus.m_data        = (buf_count != 2'd0) ? buf_mem[head] : '0;
   assign bus.busy          = (state == S_READ) || (state == S_DRAIN);
   assign bus.done          = (state == S_DONE);
   assign bus.err_underflow = err_q;

   cap_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(capture && (buf_count == 2'd3)));

endmodule
